// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select encoding and
// the scoreboard entry that tracks one in-flight destination register.
package hazard_pkg;

    localparam int SB_ADDR_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    // dest is held at a fixed maximum width so the struct is parameter-free
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

    localparam logic [SB_ADDR_W-1:0] NOP_DEST = 8'd0;
    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: NOP_DEST, is_load: 1'b0};

endpackage

// File: rtl/pipeline_hazard_unit_match.sv
// Priority match of one decode operand against the scoreboard: youngest
// matching entry selects the forwarding path, or flags a load-use hazard.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int LOAD_STAGE  = 2,
    parameter int ZERO_REG_EN = 0
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [SB_ADDR_W-1:0]  src_addr_i,
    input  logic                  src_used_i,
    output logic [1:0]            fwd_sel_o,
    output logic                  load_use_o
);

    logic [DEPTH-1:0] match_s;
    logic             zero_blk_s;
    logic             hit_s;
    logic             win_load_s;
    int               win_idx_s;

    // Per-entry match, then walk oldest to youngest so the youngest hit wins
    always_comb begin
        zero_blk_s = (ZERO_REG_EN != 0) && (src_addr_i == NOP_DEST);
        hit_s      = 1'b0;
        win_load_s = 1'b0;
        win_idx_s  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = entries_i[i].valid && (entries_i[i].dest == src_addr_i)
                         && src_used_i && !zero_blk_s;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                hit_s      = 1'b1;
                win_idx_s  = i;
                win_load_s = entries_i[i].is_load;
            end else begin
                hit_s      = hit_s;
                win_idx_s  = win_idx_s;
                win_load_s = win_load_s;
            end
        end
        if (hit_s && win_load_s && (win_idx_s < LOAD_STAGE)) begin
            fwd_sel_o  = FWD_RF;
            load_use_o = 1'b1;
        end else if (hit_s) begin
            fwd_sel_o  = 2'(win_idx_s + 1);
            load_use_o = 1'b0;
        end else begin
            fwd_sel_o  = FWD_RF;
            load_use_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and forwarding controller: shifting destination scoreboard,
// load-use stall, taken-branch flush and saturating stall/flush counters.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int DEPTH        = 3,
    parameter int LOAD_STAGE   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16,
    parameter int ZERO_REG_EN  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_en,
    input  logic [REG_ADDR_W-1:0] src_a_addr,
    input  logic                  src_a_used,
    input  logic [REG_ADDR_W-1:0] src_b_addr,
    input  logic                  src_b_used,
    input  logic [REG_ADDR_W-1:0] dest_addr,
    input  logic                  dest_we,
    input  logic                  dest_is_load,
    input  logic                  branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_fd,
    output logic                  bubble_de,
    output logic                  flush_fd,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_ZERO = {FC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [FC_W-1:0]       flush_ctr_q, flush_ctr_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic       lu_a_s, lu_b_s;
    logic [1:0] sel_a_s, sel_b_s;
    logic       flush_act_s, stall_s, bubble_s;

    hazard_match #(
        .DEPTH       (DEPTH),
        .LOAD_STAGE  (LOAD_STAGE),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match_a (
        .entries_i  (sb_q),
        .src_addr_i (SB_ADDR_W'(src_a_addr)),
        .src_used_i (src_a_used),
        .fwd_sel_o  (sel_a_s),
        .load_use_o (lu_a_s)
    );

    hazard_match #(
        .DEPTH       (DEPTH),
        .LOAD_STAGE  (LOAD_STAGE),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match_b (
        .entries_i  (sb_q),
        .src_addr_i (SB_ADDR_W'(src_b_addr)),
        .src_used_i (src_b_used),
        .fwd_sel_o  (sel_b_s),
        .load_use_o (lu_b_s)
    );

    // Flush beats stall; a frozen pipeline never asserts either
    always_comb begin
        flush_act_s = pipe_en & (branch_taken | (flush_ctr_q != FC_ZERO));
        stall_s     = pipe_en & (lu_a_s | lu_b_s) & ~flush_act_s;
        bubble_s    = stall_s | flush_act_s;
    end

    // Next state: scoreboard shift, flush countdown, saturating counters
    always_comb begin
        sb_d        = sb_q;
        flush_ctr_d = flush_ctr_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pipe_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_d[i] = sb_q[i-1];
            end
            // a bubbled or squashed decode instruction never reaches EX
            sb_d[0] = '{valid:   dest_we & ~bubble_s,
                        dest:    SB_ADDR_W'(dest_addr),
                        is_load: dest_is_load};
            if (branch_taken) begin
                flush_ctr_d = FC_LOAD;
            end else if (flush_ctr_q != FC_ZERO) begin
                flush_ctr_d = flush_ctr_q - FC_W'(1);
            end else begin
                flush_ctr_d = flush_ctr_q;
            end
            if (stall_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (branch_taken && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else begin
            sb_d        = sb_q;
            flush_ctr_d = flush_ctr_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q        <= {DEPTH{SB_EMPTY}};
            flush_ctr_q <= FC_ZERO;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            sb_q        <= sb_d;
            flush_ctr_q <= flush_ctr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a_sel   = sel_a_s;
    assign fwd_b_sel   = sel_b_s;
    assign stall_fd    = stall_s;
    assign bubble_de   = bubble_s;
    assign flush_fd    = flush_act_s;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: each stimulus cycle queues its expected outputs; a negedge
// monitor pops and compares. Three instances cover default, CNT_W=4, zero-reg.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       reset, pipe_en;
    logic [3:0] src_a_addr, src_b_addr, dest_addr;
    logic       src_a_used, src_b_used, dest_we, dest_is_load, branch_taken;

    logic [1:0]  m_a, m_b, s_a, s_b, z_a, z_b;
    logic        m_st, m_bu, m_fl, s_st, s_bu, s_fl, z_st, z_bu, z_fl;
    logic [15:0] m_sc, m_fc, z_sc, z_fc;
    logic [3:0]  s_sc, s_fc;

    typedef struct {
        int         dut;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ef;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit u_main (
        .clk(clk), .reset(reset), .pipe_en(pipe_en),
        .src_a_addr(src_a_addr), .src_a_used(src_a_used),
        .src_b_addr(src_b_addr), .src_b_used(src_b_used),
        .dest_addr(dest_addr), .dest_we(dest_we), .dest_is_load(dest_is_load),
        .branch_taken(branch_taken),
        .fwd_a_sel(m_a), .fwd_b_sel(m_b), .stall_fd(m_st), .bubble_de(m_bu),
        .flush_fd(m_fl), .stall_count(m_sc), .flush_count(m_fc)
    );

    pipeline_hazard_unit #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .pipe_en(pipe_en),
        .src_a_addr(src_a_addr), .src_a_used(src_a_used),
        .src_b_addr(src_b_addr), .src_b_used(src_b_used),
        .dest_addr(dest_addr), .dest_we(dest_we), .dest_is_load(dest_is_load),
        .branch_taken(branch_taken),
        .fwd_a_sel(s_a), .fwd_b_sel(s_b), .stall_fd(s_st), .bubble_de(s_bu),
        .flush_fd(s_fl), .stall_count(s_sc), .flush_count(s_fc)
    );

    pipeline_hazard_unit #(.ZERO_REG_EN(1)) u_zero (
        .clk(clk), .reset(reset), .pipe_en(pipe_en),
        .src_a_addr(src_a_addr), .src_a_used(src_a_used),
        .src_b_addr(src_b_addr), .src_b_used(src_b_used),
        .dest_addr(dest_addr), .dest_we(dest_we), .dest_is_load(dest_is_load),
        .branch_taken(branch_taken),
        .fwd_a_sel(z_a), .fwd_b_sel(z_b), .stall_fd(z_st), .bubble_de(z_bu),
        .flush_fd(z_fl), .stall_count(z_sc), .flush_count(z_fc)
    );

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            int a, b, st, bu, fl, sc, fc;
            e = exp_q.pop_front();
            case (e.dut)
                0: begin a = m_a; b = m_b; st = m_st; bu = m_bu; fl = m_fl; sc = m_sc; fc = m_fc; end
                1: begin a = s_a; b = s_b; st = s_st; bu = s_bu; fl = s_fl; sc = s_sc; fc = s_fc; end
                2: begin a = z_a; b = z_b; st = z_st; bu = z_bu; fl = z_fl; sc = z_sc; fc = z_fc; end
                default: begin a = 0; b = 0; st = 0; bu = 0; fl = 0; sc = 0; fc = 0; end
            endcase
            if (e.dut >= 0) begin
                chk("fwd_a_sel", a, int'(e.ea));
                chk("fwd_b_sel", b, int'(e.eb));
                chk("stall_fd", st, int'(e.es));
                chk("flush_fd", fl, int'(e.ef));
                chk("bubble_de", bu, int'(e.es | e.ef));
                if (e.sc >= 0) chk("stall_count", sc, e.sc);
                if (e.fc >= 0) chk("flush_count", fc, e.fc);
            end
        end
    end

    task automatic cyc(input logic rs, input logic en,
                       input logic [3:0] sa, input logic ua,
                       input logic [3:0] sbb, input logic ub,
                       input logic [3:0] d, input logic we, input logic ld,
                       input logic br, input int dut,
                       input logic [1:0] ea, input logic [1:0] eb,
                       input logic es, input logic ef, input int sc, input int fc);
        exp_t e;
        reset = rs; pipe_en = en;
        src_a_addr = sa; src_a_used = ua; src_b_addr = sbb; src_b_used = ub;
        dest_addr = d; dest_we = we; dest_is_load = ld; branch_taken = br;
        e.dut = dut; e.ea = ea; e.eb = eb; e.es = es; e.ef = ef; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pipe_en = 1'b0;
        src_a_addr = 4'd0; src_a_used = 1'b0; src_b_addr = 4'd0; src_b_used = 1'b0;
        dest_addr = 4'd0; dest_we = 1'b0; dest_is_load = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, -1, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, -1, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        // reset state
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 0);
        // ALU forwarding from EX, MEM, WB
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 0, 2'd1, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd2, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd7, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd2, 2'd3, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd0, 2'd3, 1'b0, 1'b0, -1, -1);
        // load r5 then use on B: two stall cycles, then WB forward
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b1, 1'b0, 0, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b1, 1'b0, 1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd3, 1'b0, 1'b0, 2, 0);
        // r2 in both EX and MEM: youngest wins
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd1, 2'd3, 1'b0, 1'b0, -1, -1);
        // branch while a load-use stall is pending
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 0, 2'd0, 2'd0, 1'b0, 1'b1, 2, 0);
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b1, 2, 1);
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd3, 2'd0, 1'b0, 1'b0, 2, 1);
        // pipe_en=0 freezes state and masks control outputs
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b0, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 2'd1, 2'd0, 1'b0, 1'b0, 2, 1);
        cyc(1'b0, 1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd1, 2'd0, 1'b0, 1'b0, 2, 1);
        // back-to-back branches reload the flush counter
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 2'd0, 2'd0, 1'b0, 1'b1, -1, 1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 2'd0, 2'd0, 1'b0, 1'b1, -1, 2);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b1, -1, 3);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, 2, 3);
        // fill scoreboard, start a flush, reset in the middle
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd12, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 2'd1, 2'd0, 1'b0, 1'b1, -1, -1);
        cyc(1'b1, 1'b1, 4'd12, 1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, -1, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd12, 1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 0);
        // chained loads r5 <- [r5]: 20 stall cycles on the 4-bit counter instance
        for (int k = 1; k <= 31; k++) begin
            logic [1:0] ea_k;
            logic       es_k;
            int         sc_k;
            ea_k = 2'd0;
            es_k = 1'b0;
            if (k == 1) begin
                ea_k = 2'd0; es_k = 1'b0;
            end else if ((k % 3) == 1) begin
                ea_k = 2'd3; es_k = 1'b0;
            end else begin
                ea_k = 2'd0; es_k = 1'b1;
            end
            sc_k = (k == 20) ? 12 : -1;
            cyc(1'b0, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1, ea_k, 2'd0, es_k, 1'b0, sc_k, -1);
        end
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1, 2'd0, 2'd0, 1'b0, 1'b0, 15, 0);
        // hard-zero register instance: load r0 then read r0
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 2, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2, 2'd0, 2'd3, 1'b0, 1'b0, -1, -1);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, -1, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1);
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Hazard detection and forwarding controller for the 16-bit pipelined CPU (Fetch, Decode, Execute, Memory, Writeback). It keeps a shifting scoreboard of in-flight destination registers, one entry per post-decode stage. From that scoreboard it drives the decode-stage operand forwarding selects, load-use stalls and branch flushes. It also keeps saturating stall/flush performance counters. It sits beside controlUnit and feeds the PC_register enable, the FetchDecode_register hold/flush inputs and the DecodeExecute_register bubble input.

Parameters:
REG_ADDR_W, 4, register address width
DEPTH, 3, post-decode stages tracked (index 0 = EX, 1 = MEM, 2 = WB)
LOAD_STAGE, 2, first stage index whose load data is forwardable (RAM read is synchronous)
FLUSH_CYCLES, 2, younger-instruction slots squashed on a taken branch
CNT_W, 16, performance counter width
ZERO_REG_EN, 0, 1 = register 0 never matches (hard zero)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pipe_en  in  1  global advance enable; 0 freezes all state
src_a_addr  in  REG_ADDR_W  decode operand A register
src_a_used  in  1  decode instruction reads A
src_b_addr  in  REG_ADDR_W  decode operand B register
src_b_used  in  1  decode instruction reads B
dest_addr  in  REG_ADDR_W  decode destination register
dest_we  in  1  decode instruction writes a register (wre)
dest_is_load  in  1  decode instruction is a memory load
branch_taken  in  1  execute-stage taken branch (selectNextPC)
fwd_a_sel  out  2  0 regfile, 1 EX result, 2 MEM result, 3 WB data
fwd_b_sel  out  2  same encoding for operand B
stall_fd  out  1  hold PC and FetchDecode_register
bubble_de  out  1  load NOP into DecodeExecute_register
flush_fd  out  1  clear FetchDecode_register
stall_count  out  CNT_W  cycles with stall_fd=1, saturating
flush_count  out  CNT_W  taken-branch events, saturating

Behaviour:
- Scoreboard: DEPTH entries of {valid, dest, is_load}.
- On each clk with pipe_en=1 and reset=0, entries shift: entry[i] <= entry[i-1].
- entry[0] <= {dest_we & ~bubble_de, dest_addr, dest_is_load}. The oldest entry falls off.
- Matching:
  - Entry i matches operand X when valid, dest == src_X_addr and src_X_used.
  - With ZERO_REG_EN=1, address 0 never matches.
  - The youngest match (lowest i) wins.
- Forwarding:
  - fwd_X_sel = i+1 of the winning entry; 0 if no match.
  - If the winner is a load with i < LOAD_STAGE, that is a load-use hazard: fwd_X_sel = 0 and the stall asserts.
  - Forwarding outputs are combinational from scoreboard and inputs.
- Stall:
  - stall_fd = bubble_de = load-use hazard on A or B, and no flush active.
  - A stall inserts exactly one bubble per cycle and repeats until the load reaches LOAD_STAGE.
  - With defaults, a dependent instruction directly behind a load stalls 2 cycles.
- Flush:
  - branch_taken=1 with pipe_en=1 loads flush_ctr <= FLUSH_CYCLES-1.
  - flush_fd = bubble_de = branch_taken | (flush_ctr != 0).
  - flush_ctr decrements while nonzero and pipe_en=1.
  - With defaults, flush_fd is high for exactly 2 cycles from the branch cycle.
- Priority:
  - A flush overrides a stall in the same cycle: stall_fd=0, and the squashed instruction is not recorded.
  - branch_taken during an active flush reloads the counter.
- pipe_en=0: scoreboard, flush_ctr and counters hold; stall_fd, bubble_de and flush_fd are forced to 0.
- Counters:
  - stall_count increments on cycles with stall_fd=1.
  - flush_count increments on cycles with branch_taken=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset, including mid-stall or mid-flush: all entries invalid, flush_ctr=0, both counters 0.
  - Consequently stall_fd=0, flush_fd=0, bubble_de=0, fwd_a_sel=fwd_b_sel=0 in the following cycle.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
  - sb_entry_t struct {valid, dest, is_load}.
  - Constant NOP_DEST.
- One sub-module, hazard_match: combinational, parametrised on DEPTH. It performs the priority match for one operand and returns {fwd_sel, load_use}. It is instantiated twice (A, B).

Test Plan:
- ADD r3 in decode, next instruction reads r3 on A -> cycle after: fwd_a_sel=1; two cycles after: fwd_a_sel=2 (WB not yet, since the instruction in between is unrelated).
- Load r5, then an instruction using r5 on B -> stall_fd=bubble_de=1 for 2 cycles, then fwd_b_sel=3 for one cycle; stall_count=2.
- r2 written by EX and by MEM entries, read on A -> fwd_a_sel=1 (youngest wins).
- branch_taken pulse while a load-use stall is pending -> flush_fd=1 for 2 cycles, stall_fd=0, flush_count=1, squashed dest not forwarded.
- CNT_W=4, stall held 20 cycles -> stall_count saturates at 15.
- reset=1 asserted mid-flush with scoreboard full -> next cycle all outputs 0; a read of a previously in-flight register -> fwd_sel=0.
- ZERO_REG_EN=1, write r0 then read r0 -> fwd_a_sel=0, no stall.
